imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Write-side companion to the MIPS instruction memory: boots program code at run time instead of $readmemh.
//  Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
//  Issues one word-aligned write per word into the writable instruction RAM, whose read port feeds fetch.
//  Holds the processor in reset until the image is loaded.
// PARAMETERS
//  SIZE   32  instruction memory depth in words; loads larger than SIZE are rejected
//  AW     $clog2(SIZE)+1  width of the word-count input
// PORTS
//  clk        in   1   system clock; all state updates on posedge
//  reset      in   1   synchronous, active-high reset
//  start      in   1   1-cycle pulse: begin a load of nwords words
//  nwords     in   AW  number of words to load, sampled on start
//  byte_in    in   8   stream data byte
//  byte_valid in   1   byte_in is valid
//  byte_ready out  1   loader accepts byte_in this cycle
//  we         out  1   instruction-memory write enable (1-cycle pulse per word)
//  wadr       out  32  byte address of the write, word aligned (wadr[1:0]=0)
//  wd         out  32  write data (assembled word)
//  cpu_reset  out  1   processor reset hold; deasserted only after a good load
//  done       out  1   load finished (valid with error)
//  error      out  1   load rejected or failed
// BEHAVIOUR
//  - Reset values: byte_ready=0, we=0, wadr=0, wd=0, cpu_reset=1, done=0, error=0; FSM->IDLE; counters cleared.
//  - FSM states: IDLE, LOAD, WRITE, DONE (+CHECK under the macro).
//  - IDLE: cpu_reset=1, byte_ready=0. On start, latch nwords, clear word_idx/byte_cnt/error/done:
//      nwords==0 -> DONE, error=0; nwords>SIZE -> DONE, error=1; otherwise -> LOAD.
//  - LOAD: byte_ready=1. A byte transfers iff byte_valid&&byte_ready; otherwise nothing changes.
//      Shift register: word <= {word[23:0],byte_in}; the first byte received lands in word[31:24].
//      byte_cnt 0..3, wraps 3->0; on the 4th accepted byte -> WRITE.
//  - WRITE: exactly one cycle, we=1, wadr={word_idx,2'b00}, wd=assembled word, byte_ready=0.
//      Write lands the cycle after the 4th byte's handshake.
//      If word_idx==nwords-1 -> DONE (or CHECK); else word_idx++ and -> LOAD.
//  - Throughput: with byte_valid held high, one word per 5 cycles.
//  - DONE: done=1, byte_ready=0, we=0; cpu_reset=error. Held until reset or start.
//      start in DONE behaves as start in IDLE (done=0, cpu_reset=1 the next cycle).
//  - start while in LOAD/WRITE/CHECK is ignored.
//  - Bytes offered outside LOAD are not accepted (byte_ready=0); the source must hold them.
//  - wadr/wd hold their last values outside WRITE; only we qualifies them.
//  - Reset mid-load aborts immediately to reset values; words already written stay in memory.
//  - word_idx arithmetic is AW bits, so no overflow for nwords<=SIZE.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined:
//    - After the last WRITE, go to CHECK: accept 4 more bytes (same handshake and byte order) as a trailer.
//    - Running sum = sum of all written words mod 2^32.
//    - Trailer==sum -> DONE, error=0. Mismatch -> DONE, error=1, cpu_reset stays 1.
//    - nwords==0 expects trailer 0x00000000.
//  Not defined:
//    - No CHECK state and no trailer; error is set only for nwords>SIZE.
//    - Any bytes following the last word are left unaccepted.
// TESTING
//  1 reset held 2 cycles -> all outputs at reset values; cpu_reset=1.
//  2 start, nwords=2; bytes 20,08,00,05,AC,09,00,00 streamed continuously ->
//    we at wadr=0x0 wd=0x20080005, then at wadr=0x4 wd=0xAC090000 five cycles later; done=1, cpu_reset=0.
//  3 same stream with byte_valid toggled every other cycle -> identical writes, only timing stretched; no byte lost or duplicated.
//  4 start, nwords=SIZE+1 -> no we; done=1, error=1, cpu_reset=1. nwords=0 -> done=1, error=0, no we.
//  5 reset asserted after 6 bytes of a 3-word load -> one write (wadr=0) seen; outputs at reset values;
//    a new start reloads from wadr=0.
//  6 IMEM_LOADER_CHECKSUM_EN: words 0x00000001,0x00000002 with trailer 0x00000003 -> error=0, cpu_reset=0;
//    trailer 0x00000004 -> error=1, cpu_reset=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boots the writable instruction RAM from a byte stream.
// Define IMEM_LOADER_CHECKSUM_EN to require a 32-bit sum trailer.
module imem_loader #(
  parameter int SIZE = 32,
  parameter int AW   = $clog2(SIZE) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] nwords,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          we,
  output logic [31:0]   wadr,
  output logic [31:0]   wd,
  output logic          cpu_reset,
  output logic          done,
  output logic          error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, LOAD, WRITE, DONE, CHECK
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, LOAD, WRITE, DONE
  } state_t;
`endif

  state_t        state;
  state_t        next;
  logic [AW-1:0] nwords_q;
  logic [AW-1:0] word_idx;
  logic [1:0]    byte_cnt;
  logic [23:0]   word;
  logic [31:0]   assembled;
  logic          xfer;
  logic          fourth;
  logic          last;
  logic          launch;
  logic          too_big;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   sum;
`endif

  // The 4th byte is folded in combinationally so the word is
  // complete on the handshake edge itself.
  assign assembled = {word, byte_in};
  assign xfer      = byte_ready && byte_valid;
  assign fourth    = xfer && (byte_cnt == 2'd3);
  assign last      = (word_idx == nwords_q - AW'(1));
  assign launch    = start && (state == IDLE || state == DONE);
  assign too_big   = (nwords > AW'(SIZE));

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign byte_ready = (state == LOAD) || (state == CHECK);
`else
  assign byte_ready = (state == LOAD);
`endif
  assign we        = (state == WRITE);
  assign done      = (state == DONE);
  assign cpu_reset = (state == DONE) ? error : 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  // Next-state decode
  always_comb begin
    next = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          if (too_big)
            next = DONE;
          else if (nwords == '0)
`ifdef IMEM_LOADER_CHECKSUM_EN
            next = CHECK;
`else
            next = DONE;
`endif
          else
            next = LOAD;
        end
      end
      LOAD: begin
        if (fourth) next = WRITE;
      end
      WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (last) next = CHECK;
`else
        if (last) next = DONE;
`endif
        else next = LOAD;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (fourth) next = DONE;
      end
`endif
      default: next = IDLE;
    endcase
  end

  // Word assembly, write port registers and load status
  always_ff @(posedge clk) begin
    if (reset) begin
      nwords_q <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      word     <= '0;
      wadr     <= '0;
      wd       <= '0;
      error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      if (launch) begin
        nwords_q <= nwords;
        word_idx <= '0;
        byte_cnt <= '0;
        error    <= too_big;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum      <= '0;
`endif
      end
      if (xfer) begin
        word     <= {word[15:0], byte_in};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (fourth && state == LOAD) begin
        wadr <= 32'({word_idx, 2'b00});
        wd   <= assembled;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum  <= sum + assembled;
`endif
      end
      if (state == WRITE && !last)
        word_idx <= word_idx + AW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (fourth && state == CHECK)
        error <= (assembled != sum);
`endif
    end
  end

endmodule
